// File: rtl/alu_seq.sv
// rtl/alu_seq.sv - multi-cycle ALU with valid/ready handshakes and iterative MUL/MULHU/DIVU/REMU
// Optional overflow output port ovf is built when ALU_OVF_EN is defined.
module alu_seq #(
  parameter int WIDTH   = 32,
  parameter int SHAMT_W = 5
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [3:0]       control,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             flag,
  output logic             busy
`ifdef ALU_OVF_EN
  ,
  output logic             ovf
`endif
);

  localparam logic [3:0] OP_ADD = 4'b0000;
  localparam logic [3:0] OP_SUB = 4'b0001;
  localparam logic [3:0] OP_AND = 4'b0010;
  localparam logic [3:0] OP_OR  = 4'b0011;
  localparam logic [3:0] OP_XOR = 4'b0100;
  localparam logic [3:0] OP_SLL = 4'b0101;
  localparam logic [3:0] OP_SRL = 4'b0110;
  localparam logic [3:0] OP_SRA = 4'b0111;
  localparam logic [3:0] OP_LUI = 4'b1110;

  typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DONE} state_t;

  state_t               r_state;
  logic                 r_in_ready;
  logic                 r_out_valid;
  logic                 r_busy;
  logic [WIDTH-1:0]     r_result;
  logic                 r_flag;
  logic [SHAMT_W-1:0]   r_count;
  logic [1:0]           r_op;
  logic [WIDTH-1:0]     r_b;
  // r_hi/r_lo: product high/low for multiply, remainder/quotient for divide
  logic [WIDTH-1:0]     r_hi;
  logic [WIDTH-1:0]     r_lo;

  logic [WIDTH-1:0]     w_sum;
  logic [WIDTH-1:0]     w_diff;
  logic [WIDTH-1:0]     w_single_res;
  logic                 w_is_iter;
  logic [WIDTH:0]       w_mul_sum;
  logic [WIDTH:0]       w_rem_sh;
  logic                 w_div_ge;
  logic [WIDTH-1:0]     w_rem_sub;
  logic [WIDTH-1:0]     w_next_hi;
  logic [WIDTH-1:0]     w_next_lo;
  logic [WIDTH-1:0]     w_iter_res;

  assign w_sum     = a + b;
  assign w_diff    = a - b;
  assign w_is_iter = (control[3:2] == 2'b10);

  always_comb begin
    w_single_res = '0;
    case (control)
      OP_ADD:  w_single_res = w_sum;
      OP_SUB:  w_single_res = w_diff;
      OP_AND:  w_single_res = a & b;
      OP_OR:   w_single_res = a | b;
      OP_XOR:  w_single_res = a ^ b;
      OP_SLL:  w_single_res = a << b[SHAMT_W-1:0];
      OP_SRL:  w_single_res = a >> b[SHAMT_W-1:0];
      OP_SRA:  w_single_res = $signed(a) >>> b[SHAMT_W-1:0];
      OP_LUI:  w_single_res = {b[WIDTH/2-1:0], {(WIDTH/2){1'b0}}};
      default: w_single_res = '0;
    endcase
  end

  // One shift-add or restoring-divide step; b == 0 naturally yields all-ones quotient and remainder a
  assign w_mul_sum = {1'b0, r_hi} + (r_lo[0] ? {1'b0, r_b} : {(WIDTH+1){1'b0}});
  assign w_rem_sh  = {r_hi, r_lo[WIDTH-1]};
  assign w_div_ge  = (w_rem_sh >= {1'b0, r_b});
  assign w_rem_sub = w_rem_sh[WIDTH-1:0] - r_b;

  always_comb begin
    w_next_hi = '0;
    w_next_lo = '0;
    if (r_op[1]) begin
      w_next_hi = w_div_ge ? w_rem_sub : w_rem_sh[WIDTH-1:0];
      w_next_lo = {r_lo[WIDTH-2:0], w_div_ge};
    end else begin
      w_next_hi = w_mul_sum[WIDTH:1];
      w_next_lo = {w_mul_sum[0], r_lo[WIDTH-1:1]};
    end
  end

  assign w_iter_res = r_op[0] ? w_next_hi : w_next_lo;

`ifdef ALU_OVF_EN
  logic w_single_ovf;
  logic r_ovf;

  always_comb begin
    w_single_ovf = 1'b0;
    if (control == OP_ADD)
      w_single_ovf = (a[WIDTH-1] == b[WIDTH-1]) && (w_sum[WIDTH-1] != a[WIDTH-1]);
    else if (control == OP_SUB)
      w_single_ovf = (a[WIDTH-1] != b[WIDTH-1]) && (w_diff[WIDTH-1] != a[WIDTH-1]);
  end

  assign ovf = r_ovf;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ovf <= 1'b0;
    end else if (r_state == S_IDLE && in_valid) begin
      r_ovf <= w_is_iter ? 1'b0 : w_single_ovf;
    end else if (r_state == S_BUSY && r_count == SHAMT_W'(WIDTH-1)) begin
      r_ovf <= (r_op == 2'b00) && (w_next_hi != '0);
    end
  end
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_in_ready  <= 1'b1;
      r_out_valid <= 1'b0;
      r_busy      <= 1'b0;
      r_result    <= '0;
      r_flag      <= 1'b1;
      r_count     <= '0;
      r_op        <= '0;
      r_b         <= '0;
      r_hi        <= '0;
      r_lo        <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (in_valid) begin
            r_in_ready <= 1'b0;
            if (w_is_iter) begin
              r_state <= S_BUSY;
              r_busy  <= 1'b1;
              r_count <= '0;
              r_op    <= control[1:0];
              r_b     <= b;
              r_hi    <= '0;
              r_lo    <= a;
            end else begin
              r_state     <= S_DONE;
              r_out_valid <= 1'b1;
              r_result    <= w_single_res;
              r_flag      <= (w_single_res == '0);
            end
          end
        end
        S_BUSY: begin
          r_hi    <= w_next_hi;
          r_lo    <= w_next_lo;
          r_count <= r_count + SHAMT_W'(1);
          if (r_count == SHAMT_W'(WIDTH-1)) begin
            r_state     <= S_DONE;
            r_busy      <= 1'b0;
            r_out_valid <= 1'b1;
            r_result    <= w_iter_res;
            r_flag      <= (w_iter_res == '0);
          end
        end
        S_DONE: begin
          if (out_ready) begin
            r_state     <= S_IDLE;
            r_out_valid <= 1'b0;
            r_in_ready  <= 1'b1;
          end
        end
        default: begin
          r_state     <= S_IDLE;
          r_in_ready  <= 1'b1;
          r_out_valid <= 1'b0;
          r_busy      <= 1'b0;
        end
      endcase
    end
  end

  assign in_ready  = r_in_ready;
  assign out_valid = r_out_valid;
  assign busy      = r_busy;
  assign result    = r_result;
  assign flag      = r_flag;

endmodule

// File: tb/tb_alu_seq.sv
// tb/tb_alu_seq.sv - directed self-checking bench for alu_seq
module tb_alu_seq;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] a = '0;
  logic [31:0] b = '0;
  logic [3:0]  control = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] result;
  logic        flag;
  logic        busy;
`ifdef ALU_OVF_EN
  logic        ovf;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  alu_seq #(.WIDTH(32), .SHAMT_W(5)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .control   (control),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .flag      (flag),
    .busy      (busy)
`ifdef ALU_OVF_EN
    ,
    .ovf       (ovf)
`endif
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Issue one op with out_ready high; latency is counted in negedge samples after the accept edge
  task automatic run_op(input string tag, input logic [3:0] op, input logic [31:0] av,
                        input logic [31:0] bv, input int exp_lat, input logic [31:0] exp_res,
                        input logic exp_ovf);
    int lat;
    int busy_cnt;
    @(negedge clk);
    check({tag, "_in_ready"}, 64'(in_ready), 64'd1);
    in_valid  = 1'b1;
    control   = op;
    a         = av;
    b         = bv;
    out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    lat      = 1;
    busy_cnt = 0;
    while (!out_valid && lat < 200) begin
      if (busy) busy_cnt++;
      @(negedge clk);
      lat++;
    end
    check({tag, "_lat"}, 64'(lat), 64'(exp_lat));
    check({tag, "_busy"}, 64'(busy_cnt), 64'(exp_lat - 1));
    check({tag, "_res"}, 64'(result), 64'(exp_res));
    check({tag, "_flag"}, 64'(flag), 64'(exp_res == 32'd0));
`ifdef ALU_OVF_EN
    check({tag, "_ovf"}, 64'(ovf), 64'(exp_ovf));
`else
    if (exp_ovf === 1'bx) $display("note: %s overflow expectation undefined", tag);
`endif
  endtask

  initial begin
    repeat (2) @(negedge clk);
    check("rst_in_ready", 64'(in_ready), 64'd1);
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_result", 64'(result), 64'd0);
    check("rst_flag", 64'(flag), 64'd1);
    check("rst_busy", 64'(busy), 64'd0);
    rst_n = 1'b1;

    run_op("add_wrap",   4'b0000, 32'hFFFF_FFFF, 32'h1,         1,  32'h0,         1'b0);
    run_op("add_ovf",    4'b0000, 32'h7FFF_FFFF, 32'h1,         1,  32'h8000_0000, 1'b1);
    run_op("sub_ovf",    4'b0001, 32'h8000_0000, 32'h1,         1,  32'h7FFF_FFFF, 1'b1);
    run_op("and",        4'b0010, 32'hF0F0_1234, 32'h0FF0_FF00, 1,  32'h00F0_1200, 1'b0);
    run_op("or",         4'b0011, 32'hF000_0001, 32'h0000_0F00, 1,  32'hF000_0F01, 1'b0);
    run_op("xor",        4'b0100, 32'hAAAA_5555, 32'hFFFF_FFFF, 1,  32'h5555_AAAA, 1'b0);
    run_op("sll_mask",   4'b0101, 32'h1,         32'hFFFF_FFE3, 1,  32'h8,         1'b0);
    run_op("srl",        4'b0110, 32'h8000_0000, 32'd31,        1,  32'h1,         1'b0);
    run_op("sra",        4'b0111, 32'h8000_0000, 32'h0000_0104, 1,  32'hF800_0000, 1'b0);
    run_op("lui",        4'b1110, 32'hDEAD_BEEF, 32'h0000_1234, 1,  32'h1234_0000, 1'b0);
    run_op("bad_op",     4'b1100, 32'h5,         32'h7,         1,  32'h0,         1'b0);
    run_op("mul_big",    4'b1000, 32'h0001_0000, 32'h0001_0000, 33, 32'h0,         1'b1);
    run_op("mulhu_big",  4'b1001, 32'h0001_0000, 32'h0001_0000, 33, 32'h1,         1'b0);
    run_op("mul_small",  4'b1000, 32'd12345,     32'd6789,      33, 32'h04FE_D79D, 1'b0);
    run_op("mul_max",    4'b1000, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 33, 32'h1,         1'b1);
    run_op("mulhu_max",  4'b1001, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 33, 32'hFFFF_FFFE, 1'b0);
    run_op("divu",       4'b1010, 32'd100,       32'd7,         33, 32'd14,        1'b0);
    run_op("remu",       4'b1011, 32'd100,       32'd7,         33, 32'd2,         1'b0);
    run_op("divu_zero",  4'b1010, 32'd5,         32'd0,         33, 32'hFFFF_FFFF, 1'b0);
    run_op("remu_zero",  4'b1011, 32'd5,         32'd0,         33, 32'd5,         1'b0);
    run_op("divu_max",   4'b1010, 32'hFFFF_FFFF, 32'd1,         33, 32'hFFFF_FFFF, 1'b0);
    run_op("remu_small", 4'b1011, 32'd7,         32'd9,         33, 32'd7,         1'b0);

    // Back-pressure: result held, new requests ignored while DONE
    @(negedge clk);
    in_valid  = 1'b1;
    control   = 4'b0000;
    a         = 32'd2;
    b         = 32'd3;
    out_ready = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check("bp_valid", 64'(out_valid), 64'd1);
    for (int i = 0; i < 10; i++) begin
      a = 32'd100 + 32'(i);
      @(negedge clk);
      check("bp_res", 64'(result), 64'd5);
      check("bp_in_ready", 64'(in_ready), 64'd0);
      check("bp_hold", 64'(out_valid), 64'd1);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    check("bp_release_valid", 64'(out_valid), 64'd0);
    check("bp_release_ready", 64'(in_ready), 64'd1);
    @(negedge clk);
    check("bp_no_ghost", 64'(out_valid), 64'd0);

    // Reset asserted mid-DIVU after step 10
    in_valid = 1'b1;
    control  = 4'b1010;
    a        = 32'd1000;
    b        = 32'd3;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    repeat (10) @(posedge clk);
    #2;
    check("mid_busy", 64'(busy), 64'd1);
    rst_n = 1'b0;
    #1;
    check("mid_rst_valid", 64'(out_valid), 64'd0);
    check("mid_rst_busy", 64'(busy), 64'd0);
    check("mid_rst_ready", 64'(in_ready), 64'd1);
    @(negedge clk);
    rst_n = 1'b1;
    run_op("add_after_rst", 4'b0000, 32'd2, 32'd3, 1, 32'd5, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
